// File: rtl/gradient_accumulate.sv
// gradient_accumulate
//
// Gradient accumulation stage that sits after the X*theta product stage.
// On start it snapshots X, X_theta and y, then walks the rows one per
// clock. For each row it forms e = X_theta[r] - y[r] (32-bit wrap) and adds
// the 48-bit signed product X[r][j]*e into acc[j] for every column j at
// once. One cycle after the last row, grad[j] is loaded with acc[j] >>> SHIFT.
//
// Handshake: start is sampled only while idle. The accepting edge raises
// busy. busy stays high for m+1 cycles. done pulses for one cycle on the edge
// that updates grad, and busy drops on that same edge. start is ignored while
// busy or while grad is being loaded; it is never queued. Holding start high
// therefore restarts on the first idle edge after done, giving a period of
// m+2 cycles. rst (synchronous, active-high) aborts any run without a done
// pulse and clears grad.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    request a new computation
//   X        16-bit signed design matrix; row i col j at [16*(m-i)*n-1-16*j -:16]
//   X_theta  32-bit signed hypotheses; row i at [32*m-1-32*i -:32]
//   y        32-bit signed labels; row i at [32*m-1-32*i -:32]
//   busy     computation in progress
//   done     one-cycle pulse when grad is updated
//   grad     ACC_W-bit signed gradient; element j at [ACC_W*n-1-ACC_W*j -:ACC_W]
module gradient_accumulate #(
    parameter int m     = 20,
    parameter int n     = 3,
    parameter int ACC_W = 56,
    parameter int SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [16*m*n-1:0]     X,
    input  logic [32*m-1:0]       X_theta,
    input  logic [32*m-1:0]       y,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_W*n-1:0]    grad
);

    localparam int ROW_W = (m > 1) ? $clog2(m) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // state is kept as a named register so that checkers can bind to it.
    state_t state;
    state_t state_nx;

    logic [ROW_W-1:0]    row;
    logic                last_row;

    logic signed [15:0]  x_m  [m][n];
    logic signed [31:0]  xt_m [m];
    logic signed [31:0]  y_m  [m];

    logic signed [ACC_W-1:0] acc  [n];
    logic signed [31:0]      e;
    logic signed [47:0]      prod [n];

    assign last_row = (row == ROW_W'(m - 1));

    // Error and per-column products for the current row. Both multiplier
    // operands are signed, so the 48-bit product is exact.
    always_comb begin
        e = xt_m[row] - y_m[row];
        for (int j = 0; j < n; j++) begin
            prod[j] = x_m[row][j] * e;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)    state_nx = RUN;
            RUN:     if (last_row) state_nx = FIN;
            FIN:                   state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            grad <= '0;
            row  <= '0;
            for (int j = 0; j < n; j++) begin
                acc[j] <= '0;
            end
            for (int i = 0; i < m; i++) begin
                xt_m[i] <= '0;
                y_m[i]  <= '0;
                for (int j = 0; j < n; j++) begin
                    x_m[i][j] <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        row  <= '0;
                        for (int i = 0; i < m; i++) begin
                            xt_m[i] <= X_theta[32*m-1-32*i -: 32];
                            y_m[i]  <= y[32*m-1-32*i -: 32];
                            for (int j = 0; j < n; j++) begin
                                x_m[i][j] <= X[16*(m-i)*n-1-16*j -: 16];
                            end
                        end
                        for (int j = 0; j < n; j++) begin
                            acc[j] <= '0;
                        end
                    end
                end
                RUN: begin
                    for (int j = 0; j < n; j++) begin
                        acc[j] <= acc[j] + {{(ACC_W-48){prod[j][47]}}, prod[j]};
                    end
                    if (!last_row) begin
                        row <= row + ROW_W'(1);
                    end
                end
                FIN: begin
                    for (int j = 0; j < n; j++) begin
                        grad[ACC_W*n-1-ACC_W*j -: ACC_W] <= acc[j] >>> SHIFT;
                    end
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gradient_accumulate.sv
// Bench for gradient_accumulate: two instances (SHIFT=0 and SHIFT=2) share
// the same stimulus. Expected gradients are hand-computed constants pushed
// into a queue per instance; a monitor pops and compares on each done pulse.
module tb_gradient_accumulate;

  localparam int M = 20;
  localparam int N = 3;
  localparam int W = 56;

  logic             clk;
  logic             rst;
  logic             start;
  logic [16*M*N-1:0] x_v;
  logic [32*M-1:0]  xt_v;
  logic [32*M-1:0]  y_v;
  logic             busy0, done0, busy1, done1;
  logic [W*N-1:0]   grad0, grad1;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int cyc = 0;

  logic [W*N-1:0] exp_q0[$];
  logic [W*N-1:0] exp_q1[$];

  gradient_accumulate #(.m(M), .n(N), .ACC_W(W), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .X(x_v), .X_theta(xt_v), .y(y_v),
    .busy(busy0), .done(done0), .grad(grad0)
  );

  gradient_accumulate #(.m(M), .n(N), .ACC_W(W), .SHIFT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .X(x_v), .X_theta(xt_v), .y(y_v),
    .busy(busy1), .done(done1), .grad(grad1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W*N-1:0] pack3(input longint a, input longint b, input longint c);
    logic [W*N-1:0] r;
    r[W*N-1 -: W]   = W'(a);
    r[W*N-1-W -: W] = W'(b);
    r[W-1:0]        = W'(c);
    return r;
  endfunction

  // driver tasks
  task automatic set_uniform(input int x0, input int x1, input int x2,
                             input int xt, input int yv, input bit ramp);
    int xv;
    for (int i = 0; i < M; i++) begin
      xt_v[32*M-1-32*i -: 32] = ramp ? 32'(i) : 32'(xt);
      y_v[32*M-1-32*i -: 32]  = 32'(yv);
      for (int j = 0; j < N; j++) begin
        xv = (j == 0) ? x0 : (j == 1) ? x1 : x2;
        x_v[16*(M-i)*N-1-16*j -: 16] = 16'(xv);
      end
    end
  endtask

  task automatic check(input string name, input longint got, input longint expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, expv);
    end
  endtask

  task automatic push_exp(input logic [W*N-1:0] e0, input logic [W*N-1:0] e1);
    exp_q0.push_back(e0);
    exp_q1.push_back(e1);
  endtask

  // Waits (bounded) for done0 at a negedge; leaves time at that negedge.
  task automatic wait_done(input string name, output int at_cyc);
    int k = 0;
    while (!done0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    at_cyc = cyc;
    checks++;
    if (!done0) begin
      failures++;
      $display("FAIL %s_timeout got=done0:0 exp=done0:1", name);
    end
  endtask

  task automatic run(input string name, input logic [W*N-1:0] e0, input logic [W*N-1:0] e1);
    int t;
    push_exp(e0, e1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(name, t);
    @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W*N-1:0] ev;
    if (done0) begin
      done_cnt++;
      checks++;
      if (exp_q0.size() == 0) begin
        failures++;
        $display("FAIL grad0_unexpected_done got=%h exp=no_done", grad0);
      end else begin
        ev = exp_q0.pop_front();
        if (grad0 !== ev) begin
          failures++;
          $display("FAIL grad0 got=%h exp=%h", grad0, ev);
        end
      end
    end
    if (done1) begin
      checks++;
      if (exp_q1.size() == 0) begin
        failures++;
        $display("FAIL grad1_unexpected_done got=%h exp=no_done", grad1);
      end else begin
        ev = exp_q1.pop_front();
        if (grad1 !== ev) begin
          failures++;
          $display("FAIL grad1 got=%h exp=%h", grad1, ev);
        end
      end
    end
  end

  initial begin
    int d_before, t1, t2;
    rst = 1'b1;
    start = 1'b0;
    x_v = '0;
    xt_v = '0;
    y_v = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", longint'(busy0), 0);
    check("reset_done", longint'(done0), 0);
    check("reset_grad0", longint'(grad0 != '0), 0);
    rst = 1'b0;
    @(negedge clk);

    // basic: e=3, X=1 -> 20*3 = 60 ; >>>2 -> 15
    set_uniform(1, 1, 1, 5, 2, 1'b0);
    run("basic", pack3(60, 60, 60), pack3(15, 15, 15));

    // signed: e=-4; col0 -2 -> 160, col2 3 -> -240
    set_uniform(-2, 0, 3, 0, 4, 1'b0);
    run("signed", pack3(160, 0, -240), pack3(40, 0, -60));

    // ramp: e=i, sum 0..19 = 190; -190>>>2 floors to -48
    set_uniform(1, 2, -1, 0, 0, 1'b1);
    run("ramp", pack3(190, 380, -190), pack3(47, 95, -48));

    // timing, start during busy and during FIN ignored
    set_uniform(1, 1, 1, 5, 2, 1'b0);
    push_exp(pack3(60, 60, 60), pack3(15, 15, 15));
    d_before = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      check($sformatf("timing_busy_c%0d", c), longint'(busy0), (c <= M + 1) ? 1 : 0);
      check($sformatf("timing_done_c%0d", c), longint'(done0), (c == M + 2) ? 1 : 0);
      if (c == 5 || c == 21) start = 1'b1;
      if (c == 6 || c == 22) start = 1'b0;
      @(negedge clk);
    end
    check("timing_single_done", longint'(done_cnt - d_before), 1);

    // input isolation and hold
    set_uniform(1, 1, 1, 5, 2, 1'b0);
    push_exp(pack3(60, 60, 60), pack3(15, 15, 15));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < M; i++) begin
      xt_v[32*M-1-32*i -: 32] = $urandom;
      y_v[32*M-1-32*i -: 32]  = $urandom;
      for (int j = 0; j < N; j++) x_v[16*(M-i)*N-1-16*j -: 16] = 16'($urandom_range(0, 65535));
    end
    wait_done("isolation", t1);
    @(negedge clk);
    for (int k = 0; k < 50; k++) begin
      check("hold_grad0", longint'(grad0 == pack3(60, 60, 60)), 1);
      check("hold_grad1", longint'(grad1 == pack3(15, 15, 15)), 1);
      @(negedge clk);
    end

    // reset mid-run at row 10
    set_uniform(-2, 0, 3, 0, 4, 1'b0);
    d_before = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", longint'(busy0), 0);
    check("midrst_done", longint'(done0), 0);
    check("midrst_grad0", longint'(grad0 != '0), 0);
    check("midrst_grad1", longint'(grad1 != '0), 0);
    repeat (25) @(negedge clk);
    check("midrst_no_done", longint'(done_cnt - d_before), 0);
    set_uniform(1, 1, 1, 5, 2, 1'b0);
    run("after_rst", pack3(60, 60, 60), pack3(15, 15, 15));

    // back-to-back with start held high
    set_uniform(-2, 0, 3, 0, 4, 1'b0);
    push_exp(pack3(160, 0, -240), pack3(40, 0, -60));
    push_exp(pack3(160, 0, -240), pack3(40, 0, -60));
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    wait_done("b2b_first", t1);
    @(negedge clk);
    wait_done("b2b_second", t2);
    start = 1'b0;
    @(negedge clk);
    check("b2b_period", longint'(t2 - t1), M + 2);
    repeat (30) @(negedge clk);

    // extremes: e wraps to -2^31, X=-2^15 -> 2^46 per row
    set_uniform(-32768, -32768, -32768, 32'h7FFFFFFF, -1, 1'b0);
    run("extreme",
        pack3(64'd1407374883553280, 64'd1407374883553280, 64'd1407374883553280),
        pack3(64'd351843720888320, 64'd351843720888320, 64'd351843720888320));

    repeat (5) @(negedge clk);
    check("queue0_drained", longint'(exp_q0.size()), 0);
    check("queue1_drained", longint'(exp_q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gradient_accumulate.md
Name: gradient_accumulate

Overview:
- Stage directly downstream of the X*theta product stage in the gradient-descent datapath.
- Consumes the packed per-row hypothesis vector X_theta, the label vector y and the design matrix X.
- Forms the error e[i] = X_theta[i] - y[i], then accumulates gradient g[j] = (sum over i of X[i][j]*e[i]) >>> SHIFT.
- Processes one row per clock under a start/busy/done handshake.

Parameters:
- m, 20: number of rows (samples), 1..256.
- n, 3: number of columns (features), 1..8.
- ACC_W, 56: accumulator and gradient element width; must be >= 48 + ceil(log2 m).
- SHIFT, 0: arithmetic right shift applied to the final sums (divide by 2^SHIFT).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new computation; sampled only in IDLE.
- X  input  16*m*n  signed 16-bit elements; row i, col j at [16*(m-i)*n-1-16*j -:16] (row 0 col 0 in the MSBs).
- X_theta  input  32*m  signed 32-bit elements; row i at [32*m-1-32*i -:32].
- y  input  32*m  signed 32-bit labels in the X_theta number format; row i at [32*m-1-32*i -:32].
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when grad is updated.
- grad  output  ACC_W*n  signed gradient; element j at [ACC_W*n-1-ACC_W*j -:ACC_W].

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, grad=0, row counter=0, accumulators=0.
- IDLE state:
  - start=1 at edge k: latch X, X_theta and y into internal registers, clear the accumulators, set row=0, go to RUN, busy=1 from edge k.
  - Inputs may change freely after edge k without affecting the result.
- RUN state:
  - At edges k+1 .. k+m, row r = 0..m-1 is processed: e = X_theta[r] - y[r], truncated to 32 bits (two's-complement wrap); acc[j] += sext(X[r][j] * e), a 48-bit signed product, for all j in parallel.
  - After the edge that processes row m-1, go to FIN.
- FIN state, at edge k+m+1:
  - grad[j] <= acc[j] >>> SHIFT.
  - done=1 for exactly that one cycle; busy=0; go to IDLE.
- Latency:
  - start to done is m+1 cycles.
  - busy is high for m+1 cycles (edges k .. k+m+1 exclusive).
- start while busy or in FIN: ignored, no queuing.
- start held high continuously: a new run is accepted on the first IDLE edge after done, so back-to-back runs have a period of m+2 cycles.
- grad holds its value until the next FIN. It is not cleared by start.
- No overflow is possible within ACC_W (by the constraint on ACC_W). No saturation logic.
- rst mid-run: aborts immediately to reset values. No done pulse. grad is cleared to 0.
- rst and start in the same cycle: rst wins.

Test Plan:
- Basic sum, default params: all X=1, all X_theta=5, all y=2, pulse start -> done after 21 cycles; grad = {60, 60, 60}.
- Signed values: X col0=-2, col1=0, col2=3 in every row; X_theta=0, y=4 (e=-4) -> grad = {160, 0, -240}. Repeat with SHIFT=2 -> {40, 0, -60}.
- Timing: start at cycle 0 -> busy=1 during cycles 1..21; done=1 only in cycle 22 (registered at edge 21). Assert start again during busy -> ignored, exactly one done pulse.
- Input isolation and hold: change X, X_theta and y to random values one cycle after start -> grad equals the result from the originally latched values. grad stays stable for 50 idle cycles.
- Reset mid-run: assert rst at row 10 -> next cycle busy=0, grad=0, no done pulse. A following start with the first test's data -> {60, 60, 60}.
- Extremes: X=-32768 everywhere, X_theta=0x7FFFFFFF, y=-1 (e wraps to -2^31) -> each grad element = 20*2^46 = 1407374883553280, with no overflow in 56 bits.
